serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 19 +
 rtl/full_adder.sv | 11 +
 rtl/serial_adder.sv | 99 +++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the rule for sizing the bit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // max(1, clog2(n)) so that the N=1 build still has a real counter bit
    function automatic int cnt_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder; master drives requests, slave
// is the adder.
interface serial_adder_if #(parameter int N = 8);
    logic         Start;
    logic         Sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic         Busy;
    logic         Done;

    modport master (output Start, Sub, A, B, Cin,
                    input  S, Cout, Ovf, Busy, Done);
    modport slave  (input  Start, Sub, A, B, Cin,
                    output S, Cout, Ovf, Busy, Done);
endinterface

// File: rtl/full_adder.sv
// One-bit full adder, the only arithmetic element of the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder/subtractor: one bit pair per clock, LSB first, with
// the sum shifted into S from the MSB end.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           Clk,
    input  logic           Rst,
    serial_adder_if.slave  bus
);
    localparam int CW = cnt_width(N);

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           fa_s, fa_c;

    full_adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    // subtract as A + ~B + 1
                    a_d     = bus.A;
                    b_d     = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Sub | bus.Cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                s_d      = s_q >> 1;
                s_d[N-1] = fa_s;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // carry_q is the carry into the MSB on this edge
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
    assign bus.Busy = (state_q == SHIFT);
    assign bus.Done = (state_q == DONE);

endmodule
